// File: rtl/stream_s2p_framer.sv
// Serial-to-parallel I/Q framer: packs samples into P_SIZE-lane beats with SOF/EOF marking.
// Optional S2P_FRAME_CNT_EN adds a 16-bit count of completed frames.
module stream_s2p_framer #(
  parameter int P_SIZE       = 16,
  parameter int TOTAL_SIZE   = 512,
  parameter int WIDTH        = 9,
  parameter int BACKPRESSURE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] din_i,
  input  logic signed [WIDTH-1:0] din_q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] dout_i [0:P_SIZE-1],
  output logic signed [WIDTH-1:0] dout_q [0:P_SIZE-1],
  output logic                    out_sof,
  output logic                    out_eof,
  output logic                    overflow
`ifdef S2P_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_cnt
`endif
);

  localparam int LW     = $clog2(P_SIZE);
  localparam int NBEATS = TOTAL_SIZE / P_SIZE;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [LW-1:0] LIDX_LAST = LW'(P_SIZE - 1);
  localparam logic [BW-1:0] BIDX_LAST = BW'(NBEATS - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
  logic signed [WIDTH-1:0] fill_re_q [0:P_SIZE-1];
  logic signed [WIDTH-1:0] fill_re_d [0:P_SIZE-1];
  logic signed [WIDTH-1:0] fill_im_q [0:P_SIZE-1];
  logic signed [WIDTH-1:0] fill_im_d [0:P_SIZE-1];
  logic signed [WIDTH-1:0] out_re_q  [0:P_SIZE-1];
  logic signed [WIDTH-1:0] out_re_d  [0:P_SIZE-1];
  logic signed [WIDTH-1:0] out_im_q  [0:P_SIZE-1];
  logic signed [WIDTH-1:0] out_im_d  [0:P_SIZE-1];
  logic signed [WIDTH-1:0] beat_re   [0:P_SIZE-1];
  logic signed [WIDTH-1:0] beat_im   [0:P_SIZE-1];
  logic [LW-1:0] lidx_q, lidx_d;
  logic [BW-1:0] bidx_q, bidx_d;
  logic          pending_q, pending_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sof_q, out_sof_d;
  logic          out_eof_q, out_eof_d;
  logic          overflow_q, overflow_d;
  logic          out_free, blocked, accept, drop, last, load;
`ifdef S2P_FRAME_CNT_EN
  logic [15:0]   frame_cnt_q, frame_cnt_d;
`endif

  always_comb begin
    out_free  = !out_valid_q || out_ready;
    blocked   = pending_q && !out_free;
    in_ready  = (BACKPRESSURE != 0) ? !blocked : 1'b1;
    accept    = in_valid && !blocked && !flush;
    drop      = (BACKPRESSURE == 0) && in_valid && blocked && !flush;
    last      = accept && (lidx_q == LIDX_LAST);
    load      = !flush && out_free && (pending_q || last);

    // A parked beat is already complete; otherwise the live sample closes the last lane.
    beat_re = fill_re_q;
    beat_im = fill_im_q;
    if (!pending_q) begin
      beat_re[P_SIZE-1] = din_i;
      beat_im[P_SIZE-1] = din_q;
    end

    fill_re_d   = fill_re_q;
    fill_im_d   = fill_im_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    lidx_d      = lidx_q;
    bidx_d      = bidx_q;
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    overflow_d  = overflow_q;

    if (accept) begin
      fill_re_d[lidx_q] = din_i;
      fill_im_d[lidx_q] = din_q;
      lidx_d            = lidx_q + 1'b1;
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_re_d    = beat_re;
      out_im_d    = beat_im;
      out_sof_d   = (bidx_q == '0);
      out_eof_d   = (bidx_q == BIDX_LAST);
      bidx_d      = (bidx_q == BIDX_LAST) ? '0 : bidx_q + 1'b1;
      pending_d   = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (last && !out_free) pending_d = 1'b1;
    if (drop) overflow_d = 1'b1;

    if (flush) begin
      lidx_d      = '0;
      bidx_d      = '0;
      pending_d   = 1'b0;
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
      overflow_d  = 1'b0;
    end

`ifdef S2P_FRAME_CNT_EN
    frame_cnt_d = frame_cnt_q;
    if (flush) frame_cnt_d = '0;
    else if (out_valid_q && out_ready && out_eof_q) frame_cnt_d = frame_cnt_q + 16'd1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < P_SIZE; k++) begin
        fill_re_q[k] <= '0;
        fill_im_q[k] <= '0;
        out_re_q[k]  <= '0;
        out_im_q[k]  <= '0;
      end
      lidx_q      <= '0;
      bidx_q      <= '0;
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef S2P_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      fill_re_q   <= fill_re_d;
      fill_im_q   <= fill_im_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      lidx_q      <= lidx_d;
      bidx_q      <= bidx_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      overflow_q  <= overflow_d;
`ifdef S2P_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign dout_i    = out_re_q;
  assign dout_q    = out_im_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign overflow  = overflow_q;
`ifdef S2P_FRAME_CNT_EN
  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_stream_s2p_framer.sv
// Bench for stream_s2p_framer: instance a runs with backpressure, instance b in drop mode.
// Expected beats are built from driven samples and compared as each beat is handed off.
module tb_stream_s2p_framer;
  localparam int P      = 16;
  localparam int T      = 512;
  localparam int W      = 9;
  localparam int NB     = T / P;
  localparam int BEAT_W = 2 * P * W;
  localparam int EXP_W  = BEAT_W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic flush_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b0;
  logic flush_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic signed [W-1:0] din_i_a = '0, din_q_a = '0, din_i_b = '0, din_q_b = '0;
  logic in_ready_a, out_valid_a, sof_a, eof_a, ovf_a;
  logic in_ready_b, out_valid_b, sof_b, eof_b, ovf_b;
  logic signed [W-1:0] dout_i_a [0:P-1];
  logic signed [W-1:0] dout_q_a [0:P-1];
  logic signed [W-1:0] dout_i_b [0:P-1];
  logic signed [W-1:0] dout_q_b [0:P-1];
`ifdef S2P_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  stream_s2p_framer #(.P_SIZE(P), .TOTAL_SIZE(T), .WIDTH(W), .BACKPRESSURE(1)) u_a (
    .clk(clk), .rst(rst), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .din_i(din_i_a), .din_q(din_q_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .dout_i(dout_i_a), .dout_q(dout_q_a), .out_sof(sof_a), .out_eof(eof_a), .overflow(ovf_a)
`ifdef S2P_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  stream_s2p_framer #(.P_SIZE(P), .TOTAL_SIZE(T), .WIDTH(W), .BACKPRESSURE(0)) u_b (
    .clk(clk), .rst(rst), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .din_i(din_i_b), .din_q(din_q_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .dout_i(dout_i_b), .dout_q(dout_q_b), .out_sof(sof_b), .out_eof(eof_b), .overflow(ovf_b)
`ifdef S2P_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  int checks = 0;
  int errors = 0;
  int beats_a = 0;
  int stalls_a = 0;
  logic [EXP_W-1:0]  exp_a[$];
  logic [EXP_W-1:0]  exp_b[$];
  logic [BEAT_W-1:0] m_beat [0:1];
  int                m_lane [0:1];
  int                m_bidx [0:1];
  logic [W-1:0]      s_i [0:31];
  logic [W-1:0]      s_q [0:31];

  task automatic check(input string tag, input logic [EXP_W-1:0] got, input logic [EXP_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_push(input int d, input logic [W-1:0] i, input logic [W-1:0] q);
    logic [EXP_W-1:0] e;
    m_beat[d][m_lane[d]*2*W +: 2*W] = {i, q};
    if (m_lane[d] == P - 1) begin
      e = {(m_bidx[d] == 0), (m_bidx[d] == NB - 1), m_beat[d]};
      if (d == 0) exp_a.push_back(e);
      else exp_b.push_back(e);
      m_lane[d] = 0;
      m_bidx[d] = (m_bidx[d] == NB - 1) ? 0 : m_bidx[d] + 1;
    end else begin
      m_lane[d]++;
    end
  endtask

  task automatic model_clear(input int d);
    m_lane[d] = 0;
    m_bidx[d] = 0;
    if (d == 0) exp_a.delete();
    else exp_b.delete();
  endtask

  function automatic logic [BEAT_W-1:0] pack_beat(input logic signed [W-1:0] di [0:P-1],
                                                  input logic signed [W-1:0] dq [0:P-1]);
    logic [BEAT_W-1:0] r;
    r = '0;
    for (int k = 0; k < P; k++) r[k*2*W +: 2*W] = {di[k], dq[k]};
    return r;
  endfunction

  // Scoreboard: pop one expected beat per output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_a && out_ready_a) begin
        beats_a++;
        if (exp_a.size() == 0) check("a_unexpected_beat", out_valid_a, 0);
        else check("a_beat", {sof_a, eof_a, pack_beat(dout_i_a, dout_q_a)}, exp_a.pop_front());
      end
      if (out_valid_b && out_ready_b) begin
        if (exp_b.size() == 0) check("b_unexpected_beat", out_valid_b, 0);
        else check("b_beat", {sof_b, eof_b, pack_beat(dout_i_b, dout_q_b)}, exp_b.pop_front());
      end
    end
  end

  task automatic send_a(input logic [W-1:0] i, input logic [W-1:0] q);
    in_valid_a = 1'b1;
    din_i_a    = i;
    din_q_a    = q;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready_a) begin
        model_push(0, i, q);
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        return;
      end
      stalls_a++;
      @(posedge clk);
      #1;
    end
    check("a_send_timeout", in_ready_a, 1);
    in_valid_a = 1'b0;
  endtask

  task automatic cycle_b(input logic [W-1:0] i, input logic [W-1:0] q, input bit keep);
    in_valid_b = 1'b1;
    din_i_b    = i;
    din_q_b    = q;
    @(negedge clk);
    check("b_in_ready", in_ready_b, 1);
    if (keep) model_push(1, i, q);
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
  endtask

  task automatic drain(input int d, input string tag);
    int n;
    n = (d == 0) ? exp_a.size() : exp_b.size();
    for (int t = 0; t < 300 && n != 0; t++) begin
      @(posedge clk);
      #1;
      n = (d == 0) ? exp_a.size() : exp_b.size();
    end
    check(tag, n, 0);
  endtask

  initial begin
    model_clear(0);
    model_clear(1);
    m_beat[0] = '0;
    m_beat[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_a, 1);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_sof", sof_a, 0);
    check("rst_eof", eof_a, 0);
    check("rst_overflow", ovf_b, 0);
    check("rst_dout", {dout_i_a[0]}, 0);
`ifdef S2P_FRAME_CNT_EN
    check("rst_frame_cnt", fc_a, 0);
`endif
    rst = 1'b0;
    out_ready_a = 1'b1;

    // First beat: I=k, Q=-k, one sample per cycle.
    for (int k = 0; k < P; k++) begin
      if (k == P - 1) check("t1_no_early_valid", out_valid_a, 0);
      send_a(W'(k), W'(-k));
    end
    check("t1_latency", out_valid_a, 1);
    check("t1_lane5_i", {dout_i_a[5]}, 9'd5);
    check("t1_lane5_q", {dout_q_a[5]}, 9'h1FB);
    check("t1_sof", sof_a, 1);
    check("t1_eof", eof_a, 0);
    drain(0, "t1_drain");

    // Full frame at one sample per cycle, starting from a flushed position.
    flush_a = 1'b1;
    @(posedge clk);
    #1;
    flush_a = 1'b0;
    model_clear(0);
    check("t2_flush_valid", out_valid_a, 0);
    stalls_a = 0;
    beats_a  = 0;
    for (int k = 0; k < T; k++) send_a(W'($urandom_range(0, 511)), W'($urandom_range(0, 511)));
    drain(0, "t2_drain");
    check("t2_no_stall", stalls_a, 0);
    check("t2_beats", beats_a, NB);
`ifdef S2P_FRAME_CNT_EN
    check("t2_frame_cnt", fc_a, 1);
`endif

    // Backpressure: two beats fit (output + parked fill), then in_ready drops.
    out_ready_a = 1'b0;
    stalls_a = 0;
    for (int k = 0; k < 32; k++) begin
      s_i[k] = W'($urandom_range(0, 511));
      s_q[k] = W'($urandom_range(0, 511));
      send_a(s_i[k], s_q[k]);
    end
    check("t3_no_stall", stalls_a, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t3_in_ready_low", in_ready_a, 0);
      check("t3_hold_valid", out_valid_a, 1);
      check("t3_hold_lane3", {dout_i_a[3]}, s_i[3]);
      check("t3_hold_lane15", {dout_q_a[15]}, s_q[15]);
    end
    check("t3_pending_beats", exp_a.size(), 2);
    @(posedge clk);
    #1;
    out_ready_a = 1'b1;
    drain(0, "t3_drain");

    // Drop mode: 40 offered into a stalled instance, last 8 are lost.
    for (int k = 0; k < 40; k++)
      cycle_b(W'($urandom_range(0, 511)), W'($urandom_range(0, 511)), k < 32);
    check("t4_overflow", ovf_b, 1);
    check("t4_pending_beats", exp_b.size(), 2);
    out_ready_b = 1'b1;
    drain(1, "t4_drain");
    out_ready_b = 1'b0;
    for (int k = 0; k < P; k++) begin
      s_i[k] = W'($urandom_range(0, 511));
      s_q[k] = W'($urandom_range(0, 511));
      cycle_b(s_i[k], s_q[k], 1'b1);
    end
    @(negedge clk);
    check("t4_overflow_sticky", ovf_b, 1);
    check("t4_beat2_valid", out_valid_b, 1);
    check("t4_beat2_lane0", {dout_i_b[0]}, s_i[0]);
    check("t4_beat2_lane15", {dout_q_b[15]}, s_q[15]);
    check("t4_beat2_sof", sof_b, 0);
    @(posedge clk);
    #1;

    // Flush seven samples into beat 3 while beat 2 is still held.
    for (int k = 0; k < 7; k++) cycle_b(W'($urandom_range(0, 511)), W'($urandom_range(0, 511)), 1'b1);
    flush_b    = 1'b1;
    in_valid_b = 1'b1;
    din_i_b    = 9'sd77;
    @(posedge clk);
    #1;
    flush_b    = 1'b0;
    in_valid_b = 1'b0;
    model_clear(1);
    check("t5_flush_valid", out_valid_b, 0);
    check("t5_flush_overflow", ovf_b, 0);
    out_ready_b = 1'b1;
    for (int k = 0; k < P; k++) cycle_b(W'($urandom_range(0, 511)), W'($urandom_range(0, 511)), 1'b1);
    drain(1, "t5_drain");

    // Asynchronous reset mid-beat with a beat held at the output.
    out_ready_a = 1'b0;
    for (int k = 0; k < P + 5; k++) send_a(W'(k + 1), W'(k + 2));
    check("t6_pre_valid", out_valid_a, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", out_valid_a, 0);
    check("t6_async_ready", in_ready_a, 1);
    check("t6_async_sof", sof_a, 0);
    check("t6_async_dout", {dout_i_a[0]}, 0);
    check("t6_async_dout_q", {dout_q_a[4]}, 0);
    model_clear(0);
    model_clear(1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready_a = 1'b1;
    for (int k = 0; k < P; k++) send_a(W'($urandom_range(0, 511)), W'($urandom_range(0, 511)));
    drain(0, "t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_s2p_framer.md
# stream_s2p_framer

Parametrised serial-to-parallel framer that packs one complex I/Q sample per accepted cycle into P_SIZE-lane parallel beats and delimits FFT frames of TOTAL_SIZE points. It is the next-generation front end of the FFT datapath and sits between the sample source and the fft_top parallel input. Over the fixed-width, free-running serial_to_parallel stage it adds:
- valid/ready handshaking on both sides;
- a one-beat output buffer;
- start/end-of-frame markers;
- a selectable drop-on-overflow mode;
- a synchronous flush.

## Interface
- P_SIZE, 16, lanes per output beat; power of two, at least 2.
- TOTAL_SIZE, 512, points per frame; a multiple of P_SIZE.
- WIDTH, 9, signed I and Q sample width.
- BACKPRESSURE, 1, selects the input mode: 1 means in_ready is honoured; 0 means in_ready is tied to 1 and blocked samples are dropped.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort of the partial beat, the buffered beat and the frame position.
- in_valid  input  1  din_i/din_q carry a sample.
- in_ready  output  1  the framer can accept a sample this cycle.
- din_i, din_q  input  WIDTH signed  serial sample.
- out_valid  output  1  dout carries a complete beat.
- out_ready  input  1  the downstream block accepts the beat.
- dout_i[0:P_SIZE-1], dout_q[0:P_SIZE-1]  output  WIDTH signed each  parallel beat; lane 0 holds the earliest sample.
- out_sof  output  1  the current beat is beat 0 of its frame.
- out_eof  output  1  the current beat is beat TOTAL_SIZE/P_SIZE-1 of its frame.
- overflow  output  1  sticky flag: a sample was dropped (BACKPRESSURE=0 only).

## Operation
- Fill register: P_SIZE lanes with a lane index lidx of width log2(P_SIZE).
  - An accepted sample (in_valid && in_ready) is written to lane lidx, then lidx increments.
- Output register: out_valid, the dout arrays, out_sof and out_eof.
- The output register is free when out_valid==0, or when out_valid && out_ready in the same cycle.
- On acceptance at lidx==P_SIZE-1:
  - If the output register is free, the beat, including the incoming sample in the last lane, moves to the output register at the next edge. lidx wraps to 0.
  - If the output register is not free, the pending flag is set and lidx wraps to 0.
- While pending==1:
  - With BACKPRESSURE=1, in_ready=0.
  - The fill beat moves to the output register on the first cycle the output register is free, and pending clears.
  - In that same cycle in_ready returns to 1 combinationally, so a new sample may be accepted into lane 0.
- BACKPRESSURE=0 mode:
  - in_ready is always 1.
  - A sample with in_valid while pending==1 and the output register is not free is discarded, and overflow is set.
  - The frame position is not advanced by a dropped sample.
- Beat counter bidx counts 0..TOTAL_SIZE/P_SIZE-1 and advances when a beat is loaded into the output register.
  - out_sof is registered as (bidx==0) and out_eof as (bidx==last) at load time.
  - bidx wraps to 0 after the last beat.
- Output data is held stable while out_valid && !out_ready.
- flush has priority over everything in the same cycle. At the next edge it sets lidx=0, pending=0, bidx=0, out_valid=0 and overflow=0. A sample presented in the flush cycle is not accepted.
- No arithmetic is performed; samples pass bit-exact.

## Timing
- Reset (async on rst high):
  - in_ready=1, out_valid=0, out_sof=0, out_eof=0, overflow=0.
  - dout lanes = 0; lidx=0, bidx=0, pending=0.
- Latency: last sample accepted in cycle N gives out_valid=1 in cycle N+1 when the output register is free.
- Sustained throughput: one sample per cycle with out_ready held at 1. Beats are then emitted every P_SIZE cycles without in_ready ever dropping.
- in_ready depends combinationally on out_valid and out_ready only; there is no path from in_valid.
- Reset mid-frame discards all state. The first beat after release is marked out_sof.

## Configuration
- Macro S2P_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt, 16 bits, reset 0.
  - frame_cnt increments on each handshake of a beat with out_eof=1, wraps at 65535→0, and is cleared by flush.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then 16 consecutive samples, I=k and Q=-k for k=0..15, with out_ready=1 → out_valid in cycle 17. Required beat: dout_i[k]=k, dout_q[k]=-k, out_sof=1, out_eof=0.
- 512 continuous samples with out_ready=1 → 32 beats. out_sof only on beat 0, out_eof only on beat 31, in_ready constantly 1. With S2P_FRAME_CNT_EN, frame_cnt=1 after beat 31.
- BACKPRESSURE=1 with out_ready=0 while 32 samples are offered → beat 0 held stable and in_ready=0 after the 32nd sample is accepted. Raising out_ready then gives beat 0 followed by beat 1 with its data intact.
- BACKPRESSURE=0 under the same stall with 40 samples offered → 8 samples dropped and overflow=1 sticky. The next beat contains samples 32..47 of the non-dropped stream.
- flush asserted after 7 samples of beat 3 → out_valid=0 and overflow=0 after the edge. The next 16 samples form a beat with out_sof=1.
- rst pulsed mid-beat with out_valid=1 → all outputs return to their reset values immediately, asynchronously, before the next clock edge.
